// File: rtl/direction_ctrl_if.sv
// rtl/direction_ctrl_if.sv - button/tick inputs and committed-direction outputs
interface direction_ctrl_if;
  logic [3:0] btn;
  logic       tick;
  logic [1:0] dir;
  logic       dir_changed;
  logic       queue_full;

  modport slave (
    input  btn,
    input  tick,
    output dir,
    output dir_changed,
    output queue_full
  );

  modport master (
    output btn,
    output tick,
    input  dir,
    input  dir_changed,
    input  queue_full
  );
endinterface

// File: rtl/direction_ctrl.sv
// rtl/direction_ctrl.sv - debounced 4-button direction input with a 2-deep turn queue
module direction_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  direction_ctrl_if.slave         ifc
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]    stable_q, stable_d, prev_q;
  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];

  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      if (ifc.btn[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) stable_d[i] = ifc.btn[i];
        else                      cnt_d[i]    = cnt_q[i] + CW'(1);
      end
    end
  end

  // Rising edge of a stable level is a press; lowest bit index wins ties.
  logic [3:0] press;
  logic       ev_valid;
  logic [1:0] ev_dir;

  assign press    = stable_q & ~prev_q;
  assign ev_valid = |press;

  always_comb begin
    ev_dir = 2'd0;
    if      (press[0]) ev_dir = 2'd0;
    else if (press[1]) ev_dir = 2'd1;
    else if (press[2]) ev_dir = 2'd2;
    else if (press[3]) ev_dir = 2'd3;
  end

  logic [1:0] mem_q [2];
  logic [1:0] mem_d [2];
  logic       head_q, head_d, tail_q, tail_d;
  logic [1:0] count_q, count_d, count_pop;
  logic [1:0] dir_q, dir_d, ref_dir;
  logic       chg_q, chg_d, full_q;
  logic       pop, push;

  always_comb begin
    mem_d     = mem_q;
    head_d    = head_q;
    tail_d    = tail_q;
    dir_d     = dir_q;
    chg_d     = 1'b0;
    pop       = ifc.tick && (count_q != 2'd0);
    count_pop = count_q;
    if (pop) begin
      dir_d     = mem_q[head_q];
      head_d    = ~head_q;
      count_pop = count_q - 2'd1;
      chg_d     = 1'b1;
    end
    // Validate against where the snake will be heading once queued turns play out.
    ref_dir = (count_pop != 2'd0) ? mem_q[~tail_q] : dir_d;
    push    = ev_valid && (ev_dir != ref_dir) && (ev_dir != ref_dir + 2'd2) &&
              (count_pop != 2'd2);
    count_d = count_pop;
    if (push) begin
      mem_d[tail_q] = ev_dir;
      tail_d        = ~tail_q;
      count_d       = count_pop + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_q <= '0;
      prev_q   <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
      mem_q[0] <= 2'd0;
      mem_q[1] <= 2'd0;
      head_q   <= 1'b0;
      tail_q   <= 1'b0;
      count_q  <= 2'd0;
      dir_q    <= 2'd1;
      chg_q    <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      stable_q <= stable_d;
      prev_q   <= stable_q;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
      mem_q    <= mem_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      dir_q    <= dir_d;
      chg_q    <= chg_d;
      full_q   <= (count_d == 2'd2);
    end
  end

  assign ifc.dir         = dir_q;
  assign ifc.dir_changed = chg_q;
  assign ifc.queue_full  = full_q;

endmodule

// File: tb/tb_direction_ctrl.sv
// tb/tb_direction_ctrl.sv - randomized and directed checks of direction_ctrl against a queue model
module tb_direction_ctrl;

  localparam int D = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  direction_ctrl_if ifc ();

  direction_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ifc   (ifc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference: per-button run-length counters plus a plain queue of pending turns.
  int m_stable [4];
  int m_prev   [4];
  int m_cnt    [4];
  int m_q [$];
  int m_dir;
  int m_chg;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_stable[i] = 0;
      m_prev[i]   = 0;
      m_cnt[i]    = 0;
    end
    m_q.delete();
    m_dir = 1;
    m_chg = 0;
  endtask

  task automatic model_step(input logic [3:0] b, input logic t);
    int ev;
    int rf;
    ev = -1;
    for (int i = 3; i >= 0; i--)
      if (m_stable[i] == 1 && m_prev[i] == 0) ev = i;
    for (int i = 0; i < 4; i++) begin
      m_prev[i] = m_stable[i];
      if (int'(b[i]) == m_stable[i]) m_cnt[i] = 0;
      else if (m_cnt[i] + 1 == D) begin
        m_stable[i] = int'(b[i]);
        m_cnt[i]    = 0;
      end else m_cnt[i]++;
    end
    m_chg = 0;
    if (t && m_q.size() > 0) begin
      m_dir = m_q.pop_front();
      m_chg = 1;
    end
    if (ev >= 0) begin
      rf = (m_q.size() > 0) ? m_q[$] : m_dir;
      if (ev != rf && ev != (rf + 2) % 4 && m_q.size() < 2) m_q.push_back(ev);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic cycle(input logic [3:0] b, input logic t);
    ifc.btn  = b;
    ifc.tick = t;
    @(posedge clk);
    model_step(b, t);
    #1;
    check("dir", int'(ifc.dir), m_dir);
    check("dir_changed", int'(ifc.dir_changed), m_chg);
    check("queue_full", int'(ifc.queue_full), (m_q.size() == 2) ? 1 : 0);
    @(negedge clk);
  endtask

  task automatic hold(input logic [3:0] b, input int n);
    for (int i = 0; i < n; i++) cycle(b, 1'b0);
  endtask

  // Called at a falling edge; asserts reset mid-phase, releases at a later falling edge.
  task automatic do_reset(input logic [3:0] b_held);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_dir", int'(ifc.dir), 1);
    check("rst_dir_changed", int'(ifc.dir_changed), 0);
    check("rst_queue_full", int'(ifc.queue_full), 0);
    model_reset();
    ifc.btn  = b_held;
    ifc.tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    ifc.btn  = 4'b0000;
    ifc.tick = 1'b0;
    model_reset();
    #1;
    rst_n = 1'b0;
    #1;
    check("por_dir", int'(ifc.dir), 1);
    check("por_dir_changed", int'(ifc.dir_changed), 0);
    check("por_queue_full", int'(ifc.queue_full), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Short glitch never qualifies.
    hold(4'b0010, 3);
    hold(4'b0000, 3);
    check("glitch_dir", int'(ifc.dir), 1);
    check("glitch_full", int'(ifc.queue_full), 0);

    // Up held 6 cycles, then a tick commits it.
    hold(4'b0001, 6);
    cycle(4'b0000, 1'b1);
    check("up_dir", int'(ifc.dir), 0);
    check("up_changed", int'(ifc.dir_changed), 1);
    cycle(4'b0000, 1'b0);
    check("up_changed_pulse", int'(ifc.dir_changed), 0);

    // Opposite of current heading is ignored.
    do_reset(4'b0000);
    hold(4'b1000, 6);
    hold(4'b0000, 2);
    cycle(4'b0000, 1'b1);
    check("opp_dir", int'(ifc.dir), 1);
    check("opp_changed", int'(ifc.dir_changed), 0);

    // Up, down (rejected), left fill the queue; right is dropped.
    hold(4'b0001, 6);
    hold(4'b0000, 2);
    hold(4'b0100, 6);
    hold(4'b0000, 2);
    hold(4'b1000, 6);
    hold(4'b0000, 2);
    check("fill_full", int'(ifc.queue_full), 1);
    hold(4'b0010, 6);
    hold(4'b0000, 5);
    check("fill_still_full", int'(ifc.queue_full), 1);

    // Tick on the push edge of a valid down press: pop then push on a full queue.
    hold(4'b0100, 4);
    cycle(4'b0100, 1'b1);
    check("popush_dir", int'(ifc.dir), 0);
    check("popush_changed", int'(ifc.dir_changed), 1);
    check("popush_full", int'(ifc.queue_full), 1);
    cycle(4'b0000, 1'b1);
    check("drain_dir_a", int'(ifc.dir), 3);
    check("drain_full_a", int'(ifc.queue_full), 0);
    cycle(4'b0000, 1'b1);
    check("drain_dir_b", int'(ifc.dir), 2);
    cycle(4'b0000, 1'b1);
    check("empty_tick_dir", int'(ifc.dir), 2);
    check("empty_tick_changed", int'(ifc.dir_changed), 0);

    // Reset mid-debounce with a queued entry; held button becomes a fresh press.
    do_reset(4'b0000);
    hold(4'b0001, 6);
    hold(4'b0100, 2);
    do_reset(4'b0100);
    hold(4'b0100, 6);
    check("post_rst_dir", int'(ifc.dir), 1);
    cycle(4'b0100, 1'b1);
    check("post_rst_tick_dir", int'(ifc.dir), 2);
    cycle(4'b0000, 1'b1);
    check("post_rst_one_entry", int'(ifc.dir_changed), 0);

    // Randomized segments.
    for (int s = 0; s < 400; s++) begin
      logic [3:0] b;
      int         len;
      if ($urandom_range(0, 3) == 0) b = 4'($urandom_range(0, 15));
      else                           b = 4'(1 << $urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) b = 4'b0000;
      len = $urandom_range(1, 9);
      if ($urandom_range(0, 59) == 0) do_reset(b);
      for (int c = 0; c < len; c++) cycle(b, ($urandom_range(0, 5) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
